gen_arbiter: RTL

- Parameterised N-way arbiter that shares one resource between requesters.
- The arbitration policy is chosen at elaboration by a generate-if on POLICY: round-robin or fixed-priority.
- It sits in front of a parameterised datapath instance. It sequences ownership, holds a grant until release, and optionally forces release after a timeout.
- Every elaborated parameter set must yield a distinct, fully specialised entity.

---
 rtl/gen_arbiter_pkg.sv | 21 ++
 rtl/gen_arbiter_pick.sv | 62 ++++++
 rtl/gen_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gen_arbiter_pkg.sv
// Shared types and helpers for the gen_arbiter resource arbiter.
package gen_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned POLICY_FIXED = 0;
    localparam int unsigned POLICY_RR    = 1;
    localparam int unsigned MAX_N        = 16;

    // One-hot vector with bit idx set; all-zero when idx is out of range.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        if ((idx < n) && (idx < MAX_N)) begin
            return MAX_N'(1) << idx;
        end
        return '0;
    endfunction

endpackage

// File: rtl/gen_arbiter_pick.sv
// Combinational winner selection; each POLICY elaborates its own search logic.
module gen_arbiter_pick
    import gen_arbiter_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned POLICY = POLICY_RR,
    parameter int unsigned IDX_W  = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     excl,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0] elig;

    assign elig = req & ~excl;

    if (POLICY == POLICY_FIXED) begin : g_fixed
        logic unused_ptr;

        assign unused_ptr = ^ptr;

        // Lowest eligible index wins.
        always_comb begin
            winner = '0;
            valid  = 1'b0;
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    winner = IDX_W'(i);
                    valid  = 1'b1;
                end
            end
        end
    end else begin : g_rr
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [IDX_W:0] off;
        logic [IDX_W:0] sum;

        // Rotate so ptr sits at bit 0, take the first hit, then map back modulo N.
        always_comb begin
            dbl   = {elig, elig};
            rot   = N'(dbl >> ptr);
            off   = '0;
            valid = 1'b0;
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    off   = (IDX_W+1)'(i);
                    valid = 1'b1;
                end
            end
            sum = (IDX_W+1)'(ptr) + off;
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            winner = IDX_W'(sum);
        end
    end

endmodule

// File: rtl/gen_arbiter.sv
// N-way arbiter: grants one owner, holds until release, optional hold timeout.
module gen_arbiter
    import gen_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned POLICY   = 1,
    parameter int unsigned HOLD_MAX = 0,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             done_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned CNT_W     = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam int unsigned HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam int unsigned PAD_W     = 1 << IDX_W;
    localparam int unsigned POL       = (POLICY > 0) ? POLICY_RR : POLICY_FIXED;

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAD_W-1:0] req_pad;
    logic [N-1:0]     excl;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             owner_req;
    logic             hold_hit;
    logic             rel;
    logic             take;

    // Padding lets owner_q index safely when N is not a power of two.
    assign req_pad   = PAD_W'(req_i);
    assign owner_req = req_pad[owner_q];
    assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_LAST));
    assign rel       = done_i | ~owner_req | hold_hit;
    assign excl      = (state_q == ST_BUSY) ? N'(onehot(32'(owner_q), N)) : '0;

    gen_arbiter_pick #(
        .N      (N),
        .POLICY (POL),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (req_i),
        .excl   (excl),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    if (POL == POLICY_RR) begin : g_ptr
        logic [IDX_W-1:0] ptr_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                ptr_q <= '0;
            end else if (take) begin
                ptr_q <= (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
            end
        end

        assign ptr = ptr_q;
    end else begin : g_no_ptr
        assign ptr = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: grant from IDLE, release or hand over back-to-back from BUSY.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        take      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = pick_vld;
            end
            ST_BUSY: begin
                if (rel) begin
                    // A timeout only flags when nothing else caused the release.
                    timeout_d = hold_hit & ~done_i & owner_req;
                    if (pick_vld) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (take) begin
            state_d = ST_BUSY;
            gnt_d   = N'(onehot(32'(pick_idx), N));
            owner_d = pick_idx;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule
